// File: rtl/chan_emu_pkg.sv
// Shared types and constants for the I/Q loopback channel emulator.
package chan_emu_pkg;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_P90 = 2'd1,
    ROT_180 = 2'd2,
    ROT_M90 = 2'd3
  } rot_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Largest positive value of a w-bit two's-complement number.
  function automatic int sat_w(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// Free-running 32-bit Galois LFSR, x^32+x^22+x^2+x+1, shifting right.
module lfsr32_galois
  import chan_emu_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEED;
    else        state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/chan_emu_iq.sv
// I/Q loopback channel emulator: rotate, gain, DC, noise, saturate, delay.
module chan_emu_iq
  import chan_emu_pkg::*;
#(
  parameter int          W     = 12,
  parameter int          G     = 8,
  parameter int          DEPTH = 64,
  parameter logic [31:0] SEED  = 32'hACE1_2024
) (
  input  logic                     clk_16M384,
  input  logic                     rst_n_16M384,
  input  logic [W-1:0]             in_I,
  input  logic [W-1:0]             in_Q,
  input  logic                     in_vld,
  input  logic                     cfg_load,
  input  logic [1:0]               cfg_rot,
  input  logic [G-1:0]             cfg_gain_num,
  input  logic [3:0]               cfg_gain_shift,
  input  logic [W-1:0]             cfg_dc_I,
  input  logic [W-1:0]             cfg_dc_Q,
  input  logic                     cfg_noise_en,
  input  logic [3:0]               cfg_noise_mag,
  input  logic [$clog2(DEPTH)-1:0] cfg_delay,
  output logic [W-1:0]             out_I,
  output logic [W-1:0]             out_Q,
  output logic                     out_vld,
  output logic [15:0]              sat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = W + G + 1;
  localparam int SW = W + G + 2;
  localparam int BW = AW + 1;
  localparam logic signed [W-1:0]  Q_MAX = W'(sat_w(W));
  localparam logic signed [W-1:0]  Q_MIN = ~Q_MAX;
  localparam logic signed [SW-1:0] S_MAX = SW'(sat_w(W));
  localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

  logic [31:0] lfsr;

  lfsr32_galois #(.SEED(SEED)) u_lfsr (
    .clk   (clk_16M384),
    .rst_n (rst_n_16M384),
    .state (lfsr)
  );

  rot_e                sh_rot;
  logic [G-1:0]        sh_gain;
  logic [3:0]          sh_shift, sh_mag;
  logic signed [W-1:0] sh_dc_i, sh_dc_q;
  logic                sh_nen;
  logic [AW-1:0]       sh_delay;
  logic [BW-1:0]       blank;

  always_ff @(posedge clk_16M384) begin
    if (!rst_n_16M384) begin
      sh_rot   <= ROT_0;
      sh_gain  <= G'(1);
      sh_shift <= '0;
      sh_dc_i  <= '0;
      sh_dc_q  <= '0;
      sh_nen   <= 1'b0;
      sh_mag   <= '0;
      sh_delay <= '0;
      blank    <= '0;
    end else begin
      if (cfg_load) begin
        sh_rot   <= rot_e'(cfg_rot);
        sh_gain  <= cfg_gain_num;
        sh_shift <= cfg_gain_shift;
        sh_dc_i  <= cfg_dc_I;
        sh_dc_q  <= cfg_dc_Q;
        sh_nen   <= cfg_noise_en;
        sh_mag   <= cfg_noise_mag;
        sh_delay <= cfg_delay;
      end
      if (cfg_load && (cfg_delay != sh_delay)) blank <= BW'(cfg_delay) + BW'(3);
      else if (blank != '0)                    blank <= blank - BW'(1);
    end
  end

  // S1: rotation; negating the most negative code clamps and flags saturation
  logic signed [W-1:0] a_i, a_q, ng_i, ng_q, r_i, r_q;
  logic                ng_i_sat, ng_q_sat, r_sat;

  always_comb begin
    a_i      = in_vld ? $signed(in_I) : '0;
    a_q      = in_vld ? $signed(in_Q) : '0;
    ng_i_sat = (a_i == Q_MIN);
    ng_q_sat = (a_q == Q_MIN);
    ng_i     = ng_i_sat ? Q_MAX : -a_i;
    ng_q     = ng_q_sat ? Q_MAX : -a_q;
    r_i      = a_i;
    r_q      = a_q;
    r_sat    = 1'b0;
    case (sh_rot)
      ROT_P90: begin r_i = ng_q; r_q = a_i;  r_sat = ng_q_sat;            end
      ROT_180: begin r_i = ng_i; r_q = ng_q; r_sat = ng_i_sat | ng_q_sat; end
      ROT_M90: begin r_i = a_q;  r_q = ng_i; r_sat = ng_i_sat;            end
      default: ;
    endcase
  end

  // Config travels with each sample so a cfg_load never splits one sample
  // across old and new settings.
  logic                 s1_vld, s1_sat, s1_nen;
  logic signed [W-1:0]  s1_i, s1_q, s1_dc_i, s1_dc_q;
  logic [G-1:0]         s1_gain;
  logic [3:0]           s1_shift, s1_mag;
  logic                 s2_vld, s2_sat, s2_nen;
  logic signed [PW-1:0] s2_pi, s2_pq;
  logic signed [W-1:0]  s2_dc_i, s2_dc_q;
  logic [3:0]           s2_shift, s2_mag;
  logic                 s3_vld;
  logic signed [W-1:0]  s3_i, s3_q;

  always_ff @(posedge clk_16M384) begin
    s1_i     <= r_i;
    s1_q     <= r_q;
    s1_gain  <= sh_gain;
    s1_shift <= sh_shift;
    s1_dc_i  <= sh_dc_i;
    s1_dc_q  <= sh_dc_q;
    s1_nen   <= sh_nen;
    s1_mag   <= sh_mag;
    s2_pi    <= PW'(s1_i) * PW'($signed({1'b0, s1_gain}));
    s2_pq    <= PW'(s1_q) * PW'($signed({1'b0, s1_gain}));
    s2_shift <= s1_shift;
    s2_dc_i  <= s1_dc_i;
    s2_dc_q  <= s1_dc_q;
    s2_nen   <= s1_nen;
    s2_mag   <= s1_mag;
    if (!rst_n_16M384) begin
      s1_vld <= 1'b0;
      s1_sat <= 1'b0;
      s2_vld <= 1'b0;
      s2_sat <= 1'b0;
    end else begin
      s1_vld <= in_vld;
      s1_sat <= in_vld & r_sat;
      s2_vld <= s1_vld;
      s2_sat <= s1_sat;
    end
  end

  // S3: shift, offset, noise, saturate
  logic [15:0]          mask, nz_i, nz_q;
  logic signed [SW-1:0] sum_i, sum_q;
  logic                 hi_i, lo_i, hi_q, lo_q;

  always_comb begin
    mask  = 16'((17'd1 << s2_mag) - 17'd1);
    nz_i  = s2_nen ? (lfsr[15:0]  & mask) : '0;
    nz_q  = s2_nen ? (lfsr[31:16] & mask) : '0;
    sum_i = (SW'(s2_pi) >>> s2_shift) + SW'(s2_dc_i) + SW'($signed({1'b0, nz_i}));
    sum_q = (SW'(s2_pq) >>> s2_shift) + SW'(s2_dc_q) + SW'($signed({1'b0, nz_q}));
    hi_i  = sum_i > S_MAX;
    lo_i  = sum_i < S_MIN;
    hi_q  = sum_q > S_MAX;
    lo_q  = sum_q < S_MIN;
  end

  always_ff @(posedge clk_16M384) begin
    s3_i <= !s2_vld ? '0 : hi_i ? Q_MAX : lo_i ? Q_MIN : sum_i[W-1:0];
    s3_q <= !s2_vld ? '0 : hi_q ? Q_MAX : lo_q ? Q_MIN : sum_q[W-1:0];
    if (!rst_n_16M384) begin
      s3_vld  <= 1'b0;
      sat_cnt <= '0;
    end else begin
      s3_vld <= s2_vld;
      if (s2_vld && (s2_sat || hi_i || lo_i || hi_q || lo_q) && (sat_cnt != '1))
        sat_cnt <= sat_cnt + 16'd1;
    end
  end

  logic [2*W-1:0] ram_d [DEPTH];
  logic [DEPTH-1:0] ram_v;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [2*W-1:0] o_d;
  logic           o_v;

  always_ff @(posedge clk_16M384) begin
    ram_d[wr_ptr] <= {s3_i, s3_q};
  end

  always_ff @(posedge clk_16M384) begin
    if (!rst_n_16M384) begin
      ram_v  <= '0;
      wr_ptr <= '0;
    end else begin
      ram_v[wr_ptr] <= s3_vld;
      wr_ptr        <= wr_ptr + AW'(1);
    end
  end

  always_comb begin
    rd_ptr = wr_ptr - sh_delay;
    if (sh_delay == '0) begin
      o_v = s3_vld;
      o_d = {s3_i, s3_q};
    end else begin
      o_v = ram_v[rd_ptr];
      o_d = ram_d[rd_ptr];
    end
  end

  always_ff @(posedge clk_16M384) begin
    if (!rst_n_16M384 || (blank != '0) || !o_v) begin
      out_I   <= '0;
      out_Q   <= '0;
      out_vld <= 1'b0;
    end else begin
      out_I   <= o_d[2*W-1:W];
      out_Q   <= o_d[W-1:0];
      out_vld <= 1'b1;
    end
  end

endmodule
